// File: rtl/prio_q_drain.sv
// Drain stage of the event priority queue: pops the queue head into a 2-entry FIFO and
// streams it out on m_valid/m_ready. The lookahead window is built when PRIO_Q_DRAIN_WINDOW_EN is defined.
module prio_q_drain #(
  parameter int WIDTH   = 32,
  parameter int CMP_WID = 32,
  parameter int DEQ_GAP = 1,
  parameter int WINDOW  = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   q_out_data,
  input  logic               q_empty,
  output logic               q_deq,
  input  logic               hold,
  input  logic [CMP_WID-1:0] gvt,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [1:0]         buf_cnt,
  output logic [CNT_W-1:0]   pop_cnt,
  output logic               win_stall
);

  localparam int GAP_W = 4;

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] pops;
  logic             gap_ok;
  logic             win_ok;
  logic             xfer;

  assign gap_ok = (gap_cnt == '0);
  assign xfer   = m_valid & m_ready;

  // The pop decision never looks at m_ready, so a full buffer blocks a pop
  // even in a cycle where the consumer drains it. Reset suppresses pops.
  assign q_deq = !rst & !q_empty & !hold & (cnt != 2'd2) & gap_ok & win_ok;

`ifdef PRIO_Q_DRAIN_WINDOW_EN
  logic [CMP_WID:0] win_lim;
  logic [CMP_WID:0] head_ts;

  // One extra bit keeps gvt + WINDOW from wrapping near the top of the time range.
  assign win_lim = {1'b0, gvt} + (CMP_WID+1)'(WINDOW);
  assign head_ts = {1'b0, q_out_data[CMP_WID-1:0]};
  assign win_ok  = (head_ts < win_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_stall <= 1'b0;
    else     win_stall <= !q_empty & !win_ok;
  end
`else
  logic unused_gvt;

  assign unused_gvt = ^gvt;
  assign win_ok     = 1'b1;
  assign win_stall  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (q_deq) begin
      gap_cnt <= GAP_W'(DEQ_GAP - 1);
    end else if (!gap_ok) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // NOTE: the two data slots are reset as well because slot0 drives m_data
  // directly and must read 0 out of reset; a larger buffer would be a RAM left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case ({q_deq, xfer})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= q_out_data;
          else             slot1 <= q_out_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        // Pop and transfer together only occur with one entry held (full blocks pops).
        2'b11: slot0 <= q_out_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pops <= '0;
    else if (xfer) pops <= pops + 1'b1;
  end

  assign m_valid = (cnt != 2'd0);
  assign m_data  = slot0;
  assign buf_cnt = cnt;
  assign pop_cnt = pops;

endmodule
